// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: locks to hsync/vsync timing, regenerates pixel coordinates
// and the visible flag, and flags any sync edge that deviates from nominal timing.
// Optional error statistics counter enabled by defining VGA_RX_STATS_EN.
module vga_sync_receiver #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       hsync_i,
    input  logic       vsync_i,
    output logic       locked_o,
    output logic       visible_o,
    output logic [9:0] position_x_o,
    output logic [9:0] position_y_o,
    output logic       err_o
`ifdef VGA_RX_STATS_EN
    ,
    output logic [7:0] err_count_o
`endif
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_X   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HE_X   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_Y   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VE_Y   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {StSearch, StAcquire, StLocked} state_e;

    state_e     state_q, state_d;
    logic       hs_q, hs_qq, vs_q, vs_qq;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic [9:0] x_next, y_next;
    logic [3:0] good_q, good_d;
    logic       err_q, err_d;
    logic       hs_fall, hs_rise, vs_fall, vs_rise;
    logic       violation;

    // Input registers, counters and FSM state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hs_q    <= 1'b1;
            hs_qq   <= 1'b1;
            vs_q    <= 1'b1;
            vs_qq   <= 1'b1;
            state_q <= StSearch;
            x_q     <= '0;
            y_q     <= '0;
            good_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            hs_q    <= hsync_i;
            hs_qq   <= hs_q;
            vs_q    <= vsync_i;
            vs_qq   <= vs_q;
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            good_q  <= good_d;
            err_q   <= err_d;
        end
    end

    // Edge detection, counter advance and timing check for the sample in hs_q/vs_q.
    always_comb begin
        hs_fall = hs_qq & ~hs_q;
        hs_rise = ~hs_qq & hs_q;
        vs_fall = vs_qq & ~vs_q;
        vs_rise = ~vs_qq & vs_q;

        x_next = (x_q == H_LAST) ? 10'd0 : x_q + 10'd1;
        y_next = y_q;
        if (x_q == H_LAST) begin
            y_next = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
        end

        // Every edge must occur exactly where expected and nowhere else.
        violation = (hs_fall != (x_q == HS_X))
                  | (hs_rise != (x_q == HE_X))
                  | (vs_fall != ((x_q == 10'd0) && (y_q == VS_Y)))
                  | (vs_rise != ((x_q == 10'd0) && (y_q == VE_Y)));
    end

    // Next-state logic for the lock FSM.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        good_d  = good_q;
        err_d   = 1'b0;
        unique case (state_q)
            StSearch: begin
                x_d    = '0;
                y_d    = '0;
                good_d = '0;
                if (vs_fall) begin
                    // This sample is pixel (0, VS); continue counting from (1, VS).
                    x_d     = 10'd1;
                    y_d     = VS_Y;
                    state_d = StAcquire;
                end
            end
            StAcquire, StLocked: begin
                x_d = x_next;
                y_d = y_next;
                if (violation) begin
                    err_d   = 1'b1;
                    state_d = StSearch;
                    x_d     = '0;
                    y_d     = '0;
                    good_d  = '0;
                end else if (state_q == StAcquire && vs_fall) begin
                    good_d = good_q + 4'd1;
                    if (good_q + 4'd1 == LOCK_N) begin
                        state_d = StLocked;
                    end
                end
            end
            default: state_d = StSearch;
        endcase
    end

    // Outputs are only meaningful while locked.
    always_comb begin
        locked_o     = (state_q == StLocked);
        visible_o    = locked_o && (x_q < H_VIS) && (y_q < V_VIS);
        position_x_o = locked_o ? x_q : 10'd0;
        position_y_o = locked_o ? y_q : 10'd0;
        err_o        = err_q;
    end

`ifdef VGA_RX_STATS_EN
    logic [7:0] err_cnt_q;

    // Saturating count of emitted err_o pulses; survives relock.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else if (err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Self-checking bench for vga_sync_receiver using a reduced-size timing so a
// full lock sequence fits in a few thousand cycles.
module tb_vga_sync_receiver;

    localparam int HV = 16, HF = 4, HSW = 6, HB = 6;
    localparam int VV = 8, VF = 2, VSW = 2, VB = 3;
    localparam int LF = 2;
    localparam int HT = HV + HF + HSW + HB;  // 32
    localparam int VT = VV + VF + VSW + VB;  // 15
    localparam int HS = HV + HF;             // 20
    localparam int HE = HS + HSW;            // 26
    localparam int VS = VV + VF;             // 10
    localparam int FRAME = HT * VT;          // 480

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       trst_n = 1'b0;
    logic       hsync_i, vsync_i;
    logic       locked_o, visible_o, err_o;
    logic [9:0] position_x_o, position_y_o;
`ifdef VGA_RX_STATS_EN
    logic [7:0] err_count_o;
`endif

    int tx = 0, ty = 0, p_tx = 0, p_ty = 0;
    bit hs_short = 1'b0, hs_kill = 1'b0, vs_stuck = 1'b0;
    bit man_en = 1'b0, man_vs = 1'b1;
    int n_vec = 0, n_bad = 0;

    typedef struct {
        int x;
        int y;
        bit vis;
    } vec_t;
    vec_t vecs[10];

    vga_sync_receiver #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .hsync_i     (hsync_i),
        .vsync_i     (vsync_i),
        .locked_o    (locked_o),
        .visible_o   (visible_o),
        .position_x_o(position_x_o),
        .position_y_o(position_y_o),
        .err_o       (err_o)
`ifdef VGA_RX_STATS_EN
        ,
        .err_count_o (err_count_o)
`endif
    );

    always #5 clk = ~clk;

    // Reference timer plus one-cycle delayed copy of its coordinates.
    always @(posedge clk) begin
        p_tx <= tx;
        p_ty <= ty;
        if (!trst_n) begin
            tx <= 0;
            ty <= 0;
        end else if (tx == HT - 1) begin
            tx <= 0;
            ty <= (ty == VT - 1) ? 0 : ty + 1;
        end else begin
            tx <= tx + 1;
        end
    end

    // Sync outputs of the timer with fault injection.
    always_comb begin
        hsync_i = !(tx >= HS && tx < HE);
        vsync_i = !(ty >= VS && ty < VS + VSW);
        if (hs_short && tx == HE - 1) hsync_i = 1'b1;
        if (hs_kill) hsync_i = 1'b1;
        if (vs_stuck) vsync_i = 1'b1;
        if (man_en) begin
            hsync_i = 1'b1;
            vsync_i = man_vs;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (p=%0d,%0d)", name, act, exp, p_tx, p_ty);
        end
    endtask

    function automatic logic [31:0] pk(input logic l, input logic e, input logic v,
                                       input int x, input int y);
        return {9'd0, l, e, v, 10'(x), 10'(y)};
    endfunction

    function automatic logic [31:0] outs();
        return {9'd0, locked_o, err_o, visible_o, position_x_o, position_y_o};
    endfunction

    task automatic timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL timeout %s: got no event expected within bound", name);
    endtask

    // Wait for the DUT to hold the sample of timer pixel (x, y).
    task automatic wait_p(input int x, input int y, input int bound, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < bound && !hit; i++) begin
            @(negedge clk);
            hit = (p_tx == x && p_ty == y);
        end
        if (!hit) timeout(name);
    endtask

    // Wait for the timer itself to present pixel (x, y).
    task automatic wait_t(input int x, input int y, input int bound, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < bound && !hit; i++) begin
            @(negedge clk);
            hit = (tx == x && ty == y);
        end
        if (!hit) timeout(name);
    endtask

    // Next vsync fall starts acquisition; lock must rise LF frames + 1 cycle later.
    task automatic sync_lock(input string name);
        wait_p(0, VS, FRAME + HT, {name, "_entry"});
        chk({name, "_entry"}, outs(), pk(0, 0, 0, 0, 0));
        repeat (LF * FRAME) @(negedge clk);
        chk({name, "_early"}, {31'd0, locked_o}, 32'd0);
        @(negedge clk);
        chk({name, "_rise"}, {31'd0, locked_o}, 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int errs;
        bit hit;
        vecs[0] = '{x: 0,  y: 0,  vis: 1'b1};
        vecs[1] = '{x: 15, y: 0,  vis: 1'b1};
        vecs[2] = '{x: 16, y: 0,  vis: 1'b0};
        vecs[3] = '{x: 15, y: 7,  vis: 1'b1};
        vecs[4] = '{x: 0,  y: 8,  vis: 1'b0};
        vecs[5] = '{x: 31, y: 14, vis: 1'b0};
        vecs[6] = '{x: 20, y: 3,  vis: 1'b0};
        vecs[7] = '{x: 5,  y: 10, vis: 1'b0};
        vecs[8] = '{x: 31, y: 7,  vis: 1'b0};
        vecs[9] = '{x: 7,  y: 4,  vis: 1'b1};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset", outs(), pk(0, 0, 0, 0, 0));
        rst_ni = 1'b1;
        trst_n = 1'b1;

        sync_lock("init");

        // One full frame tracking the delayed timer.
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            chk("frame", outs(), pk(1, 0, (p_tx < HV && p_ty < VV), p_tx, p_ty));
        end

        // Spot vectors with hand-computed visibility.
        for (int i = 0; i < 10; i++) begin
            wait_p(vecs[i].x, vecs[i].y, FRAME + 1, "vec_wait");
            chk("vec", outs(), pk(1, 0, vecs[i].vis, vecs[i].x, vecs[i].y));
        end

        // Shortened hsync pulse: rises at HE-1.
        wait_t(HS, 3, FRAME + 1, "short_arm");
        hs_short = 1'b1;
        wait_p(HE - 1, 3, HT, "short_wait");
        chk("short_pre", outs(), pk(1, 0, 0, HE - 1, 3));
        @(negedge clk);
        hs_short = 1'b0;
        chk("short_err", outs(), pk(0, 1, 0, 0, 0));
        @(negedge clk);
        chk("short_single", outs(), pk(0, 0, 0, 0, 0));
        sync_lock("short_relock");

        // Hsync held high for one whole line.
        wait_t(0, 4, FRAME + 1, "kill_arm");
        hs_kill = 1'b1;
        wait_p(HS, 4, HT, "kill_wait");
        chk("kill_pre", outs(), pk(1, 0, 0, HS, 4));
        @(negedge clk);
        chk("kill_err", outs(), pk(0, 1, 0, 0, 0));
        errs = 0;
        hit = 1'b0;
        for (int i = 0; i < 2 * HT && !hit; i++) begin
            @(negedge clk);
            errs += int'(err_o);
            hit = (tx == 0 && ty == 5);
        end
        hs_kill = 1'b0;
        if (!hit) timeout("kill_release");
        chk("kill_quiet", errs, 0);
        sync_lock("kill_relock");

        // Vsync stuck high for about a frame.
        wait_t(0, 0, FRAME + 1, "stuck_arm");
        vs_stuck = 1'b1;
        wait_p(0, VS, FRAME + 1, "stuck_wait");
        chk("stuck_pre", outs(), pk(1, 0, 0, 0, VS));
        @(negedge clk);
        chk("stuck_err", outs(), pk(0, 1, 0, 0, 0));
        errs = 0;
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME && !hit; i++) begin
            @(negedge clk);
            errs += int'(err_o);
            hit = (tx == 0 && ty == 0);
        end
        vs_stuck = 1'b0;
        if (!hit) timeout("stuck_release");
        chk("stuck_quiet", errs, 0);
        sync_lock("stuck_relock");

        // One-cycle reset mid-line while locked.
        wait_t(5, 3, FRAME + 1, "rst_arm");
        chk("rst_pre", outs(), pk(1, 0, 1, 4, 3));
        rst_ni = 1'b0;
        @(negedge clk);
        chk("rst_mid", outs(), pk(0, 0, 0, 0, 0));
        rst_ni = 1'b1;
        sync_lock("rst_relock");

`ifdef VGA_RX_STATS_EN
        rst_ni = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("stats_reset", {24'd0, err_count_o}, 32'd0);
        rst_ni = 1'b1;
        man_en = 1'b1;
        man_vs = 1'b1;
        repeat (3) @(negedge clk);
        // Each fall arms acquisition; the immediate rise at x=1 is a violation.
        for (int i = 0; i < 10; i++) begin
            man_vs = 1'b0;
            @(negedge clk);
            man_vs = 1'b1;
            @(negedge clk);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("stats_10", {24'd0, err_count_o}, 32'd10);
        for (int i = 0; i < 290; i++) begin
            man_vs = 1'b0;
            @(negedge clk);
            man_vs = 1'b1;
            @(negedge clk);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("stats_sat", {24'd0, err_count_o}, 32'd255);
        rst_ni = 1'b0;
        @(negedge clk);
        chk("stats_clear", {24'd0, err_count_o}, 32'd0);
        rst_ni = 1'b1;
        man_en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
